// File: rtl/jump_table_loader.sv
// Jump table loader: collects {address, offset} entries during a load session
// and resolves PC lookups to jump targets with one cycle of latency.
module jump_table_loader #(
    parameter int unsigned D = 12,
    parameter int unsigned N = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [D-1:0]       wr_addr,
    input  logic [D-1:0]       wr_offset,
    input  logic               wr_last,
    input  logic               lookup_en,
    input  logic [D-1:0]       lookup_addr,
    output logic               lookup_rvalid,
    output logic               lookup_hit,
    output logic [D-1:0]       lookup_target,
    output logic               busy,
    output logic               done,
    output logic               full,
    output logic               dup_err,
    output logic [$clog2(N):0] count
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = IW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    typedef struct packed {
        logic [D-1:0] addr;
        logic [D-1:0] offset;
    } entry_t;

    entry_t          tab [N];
    logic [N-1:0]    valid;
    logic [1:0]      state;
    logic [1:0]      state_next;

    logic            accept;
    logic            last_slot;
    logic            wr_hit;
    logic [IW-1:0]   wr_idx;
    logic            lk_hit;
    logic [D-1:0]    lk_off;

    // Entries are only taken mid-session, and never alongside a restart.
    assign wr_ready  = (state == ST_LOAD) && !start && !full;
    assign accept    = wr_valid && wr_ready;
    assign last_slot = (count == CW'(N - 1));

    // Find an existing valid entry with the incoming write address.
    always_comb begin
        wr_hit = 1'b0;
        wr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (tab[i].addr == wr_addr)) begin
                wr_hit = 1'b1;
                wr_idx = IW'(i);
            end
        end
    end

    // Find the entry matching the lookup PC; addresses are unique.
    always_comb begin
        lk_hit = 1'b0;
        lk_off = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (tab[i].addr == lookup_addr)) begin
                lk_hit = 1'b1;
                lk_off = tab[i].offset;
            end
        end
    end

    // Next-state logic: start always (re)opens a session.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD: begin
                if (start) begin
                    state_next = ST_LOAD;
                end else if (accept && (wr_last || (!wr_hit && last_slot))) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: if (start) state_next = ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Valid bits, occupancy and sticky session flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid   <= '0;
            count   <= '0;
            full    <= 1'b0;
            dup_err <= 1'b0;
        end else if (start) begin
            valid   <= '0;
            count   <= '0;
            full    <= 1'b0;
            dup_err <= 1'b0;
        end else if (accept) begin
            if (wr_hit) begin
                dup_err <= 1'b1;
            end else begin
                valid[count[IW-1:0]] <= 1'b1;
                count                <= count + CW'(1);
                if (last_slot) full <= 1'b1;
            end
        end
    end

    // Table payload; valid bits alone qualify hits, so no reset here.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr_hit) begin
                tab[wr_idx].offset <= wr_offset;
            end else begin
                tab[count[IW-1:0]] <= {wr_addr, wr_offset};
            end
        end
    end

    // Registered status and single-cycle lookup pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            lookup_rvalid <= 1'b0;
            lookup_hit    <= 1'b0;
            lookup_target <= '0;
        end else begin
            busy          <= (state_next == ST_LOAD);
            done          <= (state_next == ST_READY);
            lookup_rvalid <= lookup_en && (state == ST_READY);
            lookup_hit    <= lookup_en && (state == ST_READY) && lk_hit;
            lookup_target <= lk_hit ? (lookup_addr + lk_off) : lookup_addr;
        end
    end

endmodule

// File: tb/tb_jump_table_loader.sv
// Directed bench for jump_table_loader with a behavioural table model and a
// lookup scoreboard.
module tb_jump_table_loader;

    localparam int unsigned D  = 12;
    localparam int unsigned N  = 256;
    localparam int unsigned CW = $clog2(N) + 1;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_READY = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [D-1:0]  wr_addr = '0;
    logic [D-1:0]  wr_offset = '0;
    logic          wr_last = 1'b0;
    logic          lookup_en = 1'b0;
    logic [D-1:0]  lookup_addr = '0;
    logic          lookup_rvalid;
    logic          lookup_hit;
    logic [D-1:0]  lookup_target;
    logic          busy;
    logic          done;
    logic          full;
    logic          dup_err;
    logic [CW-1:0] count;

    jump_table_loader #(.D(D), .N(N)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_offset     (wr_offset),
        .wr_last       (wr_last),
        .lookup_en     (lookup_en),
        .lookup_addr   (lookup_addr),
        .lookup_rvalid (lookup_rvalid),
        .lookup_hit    (lookup_hit),
        .lookup_target (lookup_target),
        .busy          (busy),
        .done          (done),
        .full          (full),
        .dup_err       (dup_err),
        .count         (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic         v;
        logic         hit;
        logic [D-1:0] target;
    } exp_t;

    exp_t q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;

    // Behavioural model of the table and session state.
    int   mtab [int];
    int   mstate = M_IDLE;
    int   mcount = 0;
    logic mfull = 1'b0;
    logic mdup = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Scoreboard: compare each lookup result one cycle after it was issued.
    always @(negedge clk) begin
        if (reset_n) begin
            if (q.size() > 0 && q[0].due == cyc_n) begin
                exp_t e;
                e = q.pop_front();
                chk("lk_rvalid", 32'(lookup_rvalid), 32'(e.v));
                if (e.v) begin
                    chk("lk_hit", 32'(lookup_hit), 32'(e.hit));
                    chk("lk_target", 32'(lookup_target), 32'(e.target));
                end
            end else begin
                chk("lk_idle_rvalid", 32'(lookup_rvalid), 32'd0);
            end
        end
    end

    task automatic model_clear();
        mtab.delete();
        mcount = 0;
        mfull  = 1'b0;
        mdup   = 1'b0;
    endtask

    // One clock cycle of stimulus with model update and status checks.
    task automatic cyc(input logic st, input logic wv, input logic [D-1:0] a,
                       input logic [D-1:0] o, input logic lst, input logic le,
                       input logic [D-1:0] la);
        logic rdy;
        exp_t e;
        start = st; wr_valid = wv; wr_addr = a; wr_offset = o; wr_last = lst;
        lookup_en = le; lookup_addr = la;
        #1;
        rdy = (mstate == M_LOAD) && !st && !mfull;
        chk("wr_ready", 32'(wr_ready), 32'(rdy));
        if (le) begin
            e.due    = cyc_n + 1;
            e.v      = (mstate == M_READY);
            e.hit    = mtab.exists(int'(la));
            e.target = e.hit ? D'(int'(la) + mtab[int'(la)]) : la;
            q.push_back(e);
        end
        if (st) begin
            model_clear();
            mstate = M_LOAD;
        end else if (wv && rdy) begin
            if (mtab.exists(int'(a))) begin
                mdup = 1'b1;
            end else begin
                mcount++;
                if (mcount == N) mfull = 1'b1;
            end
            mtab[int'(a)] = int'(o);
            if (lst || mfull) mstate = M_READY;
        end
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(mstate == M_LOAD));
        chk("done", 32'(done), 32'(mstate == M_READY));
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mfull));
        chk("dup_err", 32'(dup_err), 32'(mdup));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic wr(input logic [D-1:0] a, input logic [D-1:0] o, input logic lst);
        cyc(1'b0, 1'b1, a, o, lst, 1'b0, '0);
    endtask

    task automatic lk(input logic [D-1:0] la);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, la);
    endtask

    task automatic go();
        cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Asynchronous reset applied away from the clock edge.
    task automatic do_reset();
        start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; lookup_en = 1'b0;
        reset_n = 1'b0;
        q.delete();
        model_clear();
        mstate = M_IDLE;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dup", 32'(dup_err), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rvalid", 32'(lookup_rvalid), 32'd0);
        chk("rst_hit", 32'(lookup_hit), 32'd0);
        chk("rst_target", 32'(lookup_target), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        do_reset();

        // Writes offered outside a session are refused.
        wr(12'h030, 12'h001, 1'b1);
        lk(12'h030);

        // Basic load, hits, one miss, back-to-back lookups.
        go();
        wr(12'h004, 12'hFFF, 1'b0);
        wr(12'h010, 12'h014, 1'b0);
        wr(12'h020, 12'h000, 1'b1);
        chk("basic_count", 32'(count), 32'd3);
        lk(12'h004);
        lk(12'h010);
        lk(12'h020);
        lk(12'h111);

        // Writes offered in READY are refused.
        wr(12'h030, 12'h001, 1'b1);
        lk(12'h030);

        // Wrap-around target and miss after a new session.
        go();
        wr(12'hFFE, 12'h005, 1'b1);
        lk(12'hFFE);
        lk(12'h111);
        lk(12'h004);

        // Duplicate address overwrites the offset.
        go();
        wr(12'h008, 12'h002, 1'b0);
        wr(12'h008, 12'hFFB, 1'b1);
        chk("dup_count", 32'(count), 32'd1);
        chk("dup_flag", 32'(dup_err), 32'd1);
        lk(12'h008);

        // Lookup coincident with start sees the old table.
        cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 12'h008);

        // Restart with a write pending drops the write.
        cyc(1'b1, 1'b1, 12'h050, 12'h001, 1'b1, 1'b0, '0);
        chk("restart_count", 32'(count), 32'd0);
        lk(12'h050);
        wr(12'h050, 12'h001, 1'b1);
        lk(12'h008);
        lk(12'h050);

        // Fill the table without wr_last.
        go();
        for (int i = 0; i < N; i++) wr(D'(i), D'(i), 1'b0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_done", 32'(done), 32'd1);
        chk("full_count", 32'(count), 32'(N));
        #1;
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        wr(12'h300, 12'h001, 1'b1);
        lk(12'h005);
        lk(12'h0FF);
        lk(12'h300);

        // Reset in the middle of a load discards the session.
        go();
        wr(12'h004, 12'h001, 1'b0);
        wr(12'h006, 12'h001, 1'b0);
        do_reset();
        lk(12'h004);
        go();
        wr(12'h100, 12'h001, 1'b1);
        lk(12'h004);
        lk(12'h100);
        idle();
        idle();
        chk("drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
